adder_subtractor_bist: RTL
==========================

# adder_subtractor_bist

Synthesizable self-test driver and checker for the `AdderSubtractor` datapath; it sits on the DUT side opposite the operand source. It drives `A`, `B` and `op`, waits a configurable latency, and samples `Result`/`CarryOut`/`Overflow`. Each sample is compared against an internal golden model over a fixed corner-case preamble followed by pseudo-random vectors. It reports pass/fail, an error count and the first failing index, so the plain and retimed/pipelined adder variants can be checked in-system.

## Interface
- `N`, 8: operand width; legal range 2..15.
- `NUM_VECTORS`, 256: total vectors per run, including the 4 corner vectors; legal range 4..65535.
- `LATENCY`, 0: DUT latency in cycles, from driven operands to valid outputs; 0 means combinational.
- `SEED`, 32'hACE1_2468: LFSR seed; must be nonzero.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begins a run when sampled in IDLE or DONE.
- `A`, `B`  out  N  registered operands to the DUT.
- `op`  out  1  registered; 0 = add, 1 = subtract.
- `Result`  in  N  DUT result.
- `CarryOut`, `Overflow`  in  1  DUT flags.
- `busy`  out  1  high in DRIVE/WAIT/CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  high when `done` is high and `err_count` is 0.
- `err_count`  out  16  mismatching vectors; saturates at 16'hFFFF.
- `first_fail_idx`  out  16  index of the first mismatch; 16'hFFFF means none.

## Operation
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE. Reset enters IDLE.
- Reset values: `A`=0, `B`=0, `op`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_idx`=16'hFFFF. Reset also sets the LFSR to SEED and `idx` to 0.
- IDLE or DONE with `start`=1:
  - clear `err_count`, `first_fail_idx`, `idx`;
  - reload the LFSR with SEED;
  - go to DRIVE.
- DRIVE: register vector `idx` onto `A`/`B`/`op`. Go to WAIT, or to CHECK if LATENCY=0.
- WAIT: stay for exactly LATENCY cycles, then go to CHECK.
- CHECK: compare `{Result, CarryOut, Overflow}` against the golden model for the held operands.
  - On a mismatch, increment `err_count` (saturating). If this is the first mismatch, load `first_fail_idx` with `idx`.
  - If `idx`=NUM_VECTORS-1, go to DONE. Otherwise increment `idx` and go to DRIVE.
- DONE: holds all results until `start` or `rst`.
- `start` is ignored while `busy` is high.
- `rst` mid-run aborts immediately to reset values. No partial results are kept.
- Vector set:
  - idx 0: A=0, B=0, add.
  - idx 1: A=all-ones, B=1, add.
  - idx 2: A=MSB-only, B=1, sub.
  - idx 3: A=MSB-clear/all-others-one (e.g. 8'h7F), B=1, add.
  - idx ≥4: A=lfsr[N-1:0], B=lfsr[2N-1:N], op=lfsr[31].
- LFSR:
  - 32-bit Fibonacci, taps 32,22,2,1, shifting toward the MSB with feedback into bit 0.
  - Advances once in each CHECK state where idx ≥4.
- Golden model, all values N bits wide:
  - add: {CarryOut,Result} = A + B; Overflow = (A[N-1]==B[N-1]) & (Result[N-1]!=A[N-1]).
  - sub: {CarryOut,Result} = A + ~B + 1, so CarryOut=1 means no borrow; Overflow = (A[N-1]!=B[N-1]) & (Result[N-1]!=A[N-1]).

## Timing
- Each vector takes LATENCY+2 cycles: DRIVE, then LATENCY cycles of WAIT, then CHECK.
- `A`/`B`/`op` change only on the DRIVE→next edge. They are stable throughout WAIT and CHECK.
- The DUT inputs `Result`, `CarryOut` and `Overflow` are sampled combinationally during CHECK and registered on its closing edge.
- `done` rises NUM_VECTORS×(LATENCY+2) cycles after the edge that sampled `start`.
- `busy` falls on the same edge that `done` rises.
- `err_count`, `first_fail_idx` and `pass` are stable whenever `done` is high.

## Test plan
- Correct behavioural DUT, N=8, LATENCY=0, 256 vectors -> `done` rises at 512 cycles; `pass`=1, `err_count`=0, `first_fail_idx`=16'hFFFF.
- DUT with `Overflow` stuck at 0 -> first error at idx 2 (8'h80−1 overflows), so `first_fail_idx`=2 and `err_count`≥2 (idx 3 also fails); `pass`=0.
- DUT with `Result[0]` inverted -> `err_count`=256, `first_fail_idx`=0.
- LATENCY=2 with a 2-stage pipelined model -> `pass`=1 at 1024 cycles. The same model with LATENCY=1 -> `pass`=0.
- Pulse `start` during vector 10, then assert `rst` during vector 20 -> the pulse has no effect. Reset values appear one edge after `rst`; a new `start` reruns from idx 0 with identical vectors.
- After DONE, assert `start` with a fixed DUT -> counters clear, the LFSR reloads SEED, and the vector sequence matches the first run exactly.

Source files
------------

// File: rtl/adder_subtractor_bist.sv
// -----------------------------------------------------------------------------
// adder_subtractor_bist
//
// Self-test driver/checker for an N-bit adder/subtractor datapath. Drives a
// fixed corner-case preamble (4 vectors) followed by LFSR pseudo-random
// vectors onto A/B/op, waits LATENCY cycles for the datapath to respond,
// and compares Result/CarryOut/Overflow against an internal golden model.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begins a run when sampled in IDLE or DONE
//   A, B, op            registered operands to the datapath (op: 0 add, 1 sub)
//   Result, CarryOut,
//   Overflow            datapath response, sampled during CHECK
//   busy                high while a run is in progress
//   done                high once the run has finished; results held
//   pass                done and no mismatches
//   err_count           mismatching vectors, saturating at 16'hFFFF
//   first_fail_idx      index of first mismatch, 16'hFFFF when none
// -----------------------------------------------------------------------------
module adder_subtractor_bist #(
    parameter int          N           = 8,
    parameter int          NUM_VECTORS = 256,
    parameter int          LATENCY     = 0,
    parameter logic [31:0] SEED        = 32'hACE1_2468
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic         op,
    input  logic [N-1:0] Result,
    input  logic         CarryOut,
    input  logic         Overflow,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  err_count,
    output logic [15:0]  first_fail_idx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] WAIT_LOAD = (LATENCY > 0) ? 16'(LATENCY - 1) : 16'd0;
    localparam logic [15:0] NO_FAIL   = 16'hFFFF;

    state_t       state_reg, state_next;
    logic [N-1:0] a_reg, a_next;
    logic [N-1:0] b_reg, b_next;
    logic         op_reg, op_next;
    logic [15:0]  idx_reg, idx_next;
    logic [15:0]  wait_reg, wait_next;
    logic [31:0]  lfsr_reg, lfsr_next;
    logic [15:0]  err_reg, err_next;
    logic [15:0]  ffi_reg, ffi_next;

    // Corner operand patterns, built bitwise so they scale with N.
    logic [N-1:0] all_ones;
    logic [N-1:0] msb_only;
    logic [N-1:0] msb_clear;
    logic [N-1:0] one_n;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_corner
            assign all_ones[gi]  = 1'b1;
            assign msb_only[gi]  = (gi == N - 1);
            assign msb_clear[gi] = (gi != N - 1);
            assign one_n[gi]     = (gi == 0);
        end
    endgenerate

    // Vector selected for the current idx.
    logic [N-1:0] vec_a;
    logic [N-1:0] vec_b;
    logic         vec_op;

    always_comb begin
        vec_a  = lfsr_reg[N-1:0];
        vec_b  = lfsr_reg[2*N-1:N];
        vec_op = lfsr_reg[31];
        case (idx_reg)
            16'd0: begin vec_a = '0;        vec_b = '0;    vec_op = 1'b0; end
            16'd1: begin vec_a = all_ones;  vec_b = one_n; vec_op = 1'b0; end
            16'd2: begin vec_a = msb_only;  vec_b = one_n; vec_op = 1'b1; end
            16'd3: begin vec_a = msb_clear; vec_b = one_n; vec_op = 1'b0; end
            default: ;
        endcase
    end

    // Fibonacci LFSR, taps 32,22,2,1, shifting toward the MSB.
    logic        lfsr_fb;
    logic [31:0] lfsr_step;
    assign lfsr_fb   = lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0];
    assign lfsr_step = {lfsr_reg[30:0], lfsr_fb};

    // Golden model on the held operands. Subtract is A + ~B + 1, so the
    // carry out is the inverted borrow.
    logic [N:0]   gold_sum;
    logic         gold_ov;
    logic         mismatch;
    assign gold_sum = {1'b0, a_reg} + {1'b0, (op_reg ? ~b_reg : b_reg)} + {{N{1'b0}}, op_reg};
    assign gold_ov  = op_reg ? ((a_reg[N-1] != b_reg[N-1]) && (gold_sum[N-1] != a_reg[N-1]))
                             : ((a_reg[N-1] == b_reg[N-1]) && (gold_sum[N-1] != a_reg[N-1]));
    assign mismatch = {Result, CarryOut, Overflow} != {gold_sum[N-1:0], gold_sum[N], gold_ov};

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        idx_next   = idx_reg;
        wait_next  = wait_reg;
        lfsr_next  = lfsr_reg;
        err_next   = err_reg;
        ffi_next   = ffi_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    err_next   = '0;
                    ffi_next   = NO_FAIL;
                    idx_next   = '0;
                    lfsr_next  = SEED;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                a_next     = vec_a;
                b_next     = vec_b;
                op_next    = vec_op;
                wait_next  = WAIT_LOAD;
                state_next = (LATENCY == 0) ? CHECK : WAIT;
            end
            WAIT: begin
                if (wait_reg == 16'd0) begin
                    state_next = CHECK;
                end else begin
                    wait_next = wait_reg - 16'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_reg != 16'hFFFF) begin
                        err_next = err_reg + 16'd1;
                    end
                    if (ffi_reg == NO_FAIL) begin
                        ffi_next = idx_reg;
                    end
                end
                // Corner vectors do not consume LFSR states.
                if (idx_reg >= 16'd4) begin
                    lfsr_next = lfsr_step;
                end
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + 16'd1;
                    state_next = DRIVE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= 1'b0;
            idx_reg   <= '0;
            wait_reg  <= '0;
            lfsr_reg  <= SEED;
            err_reg   <= '0;
            ffi_reg   <= NO_FAIL;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            idx_reg   <= idx_next;
            wait_reg  <= wait_next;
            lfsr_reg  <= lfsr_next;
            err_reg   <= err_next;
            ffi_reg   <= ffi_next;
        end
    end

    assign A              = a_reg;
    assign B              = b_reg;
    assign op             = op_reg;
    assign busy           = (state_reg == DRIVE) || (state_reg == WAIT) || (state_reg == CHECK);
    assign done           = (state_reg == DONE);
    assign pass           = done && (err_reg == 16'd0);
    assign err_count      = err_reg;
    assign first_fail_idx = ffi_reg;

endmodule
